mcu_link_ctrl: RTL and testbench
================================

Name: mcu_link_ctrl

Overview:
Parametrised successor to the single-shot MCU link controller. Sequences NUM_CFG configuration words from the microcontroller into the register map, then streams NUM_OUT result words per KF write_enable through the PTS register. Adds a slot counter instead of unrolled states, multi-word output, a per-word timeout watchdog, abort on slave-select drop, optional reconfiguration and a latched pending-write request. Sits between the rising/falling edge counters, the register map, the PTS register and the KF controller.

Parameters:
NUM_CFG, 5, number of configuration words (slots 0..NUM_CFG-1), range 1..15
NUM_OUT, 1, result words shifted out per write_enable, range 1..8
TIMEOUT_CYC, 1024, clk cycles allowed per word without a rollover, range 2..65535
RECONFIG_EN, 0, 1 = start bit accepted while configured (reconfigure)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ss_in  in  1  slave select, 1 = link active
mosi_in  in  1  MOSI data; 1 in IDLE = configuration start bit
rollover_r_in  in  1  rising-edge counter rollover (word received)
rollover_f_in  in  1  falling-edge counter rollover (word sent)
write_enable_in  in  1  KF result available (pulse)
addr_out  out  4  register-map slot to load; 4'hF = none
configured_out  out  1  all NUM_CFG slots stored
load_data_out  out  1  PTS parallel load strobe
out_sel_out  out  3  index of result word being loaded/sent
output_ready_out  out  1  MCU may clock out current word
done_out  out  1  one-cycle pulse, full result sent
r_clear_out  out  1  clear rising-edge counter
f_clear_out  out  1  clear falling-edge counter
error_out  out  1  sticky timeout/abort flag
state_out  out  4  current state encoding (debug)

Behaviour:
- Clocking: one clock, all flops update on posedge clk; rst synchronous active-high has priority over all else.
- Reset values: state IDLE, slot/out counters 0, timeout counter 0, configured_out 0, error_out 0, pending 0. Outputs are a combinational decode of the registered state, giving after reset addr_out 4'hF, r_clear_out 1, f_clear_out 1, all other outputs 0.
- States (4-bit enum): IDLE=0, CFG_LOAD=1, CFG_STORE=2, OUT_LOAD=3, OUT_SHIFT=4, OUT_DONE=5, ABORT=6.
- IDLE: r_clear_out=f_clear_out=1. While ss_in=0, stay.
  - If ss_in=1, mosi_in=1, and (configured=0 or RECONFIG_EN=1): slot:=0, configured:=0, go to CFG_LOAD.
  - Else if configured=1 and (write_enable_in or pending): out:=0, pending:=0, go to OUT_LOAD.
  - The start bit wins over a write request; the write request becomes pending.
- CFG_LOAD: wait for rollover_r_in=1, then go to CFG_STORE.
- CFG_STORE: single cycle, addr_out=slot, r_clear_out=1.
  - If slot==NUM_CFG-1: configured:=1, error:=0, go to IDLE.
  - Else slot++ and go to CFG_LOAD.
- OUT_LOAD: single cycle, load_data_out=1, f_clear_out=1, out_sel_out=out, then go to OUT_SHIFT.
- OUT_SHIFT: output_ready_out=1, out_sel_out=out. On rollover_f_in=1:
  - If out==NUM_OUT-1, go to OUT_DONE.
  - Else out++ and go to OUT_LOAD.
- OUT_DONE: done_out=1, f_clear_out=1, then go to IDLE.
- Timeout counter:
  - Cleared on entry to CFG_LOAD and OUT_SHIFT.
  - Increments each cycle in those states.
  - Reaching TIMEOUT_CYC-1 without a rollover goes to ABORT.
- ss_in=0 in any state except IDLE/ABORT goes to ABORT next cycle. This takes priority over rollover and timeout.
- ABORT: single cycle, r_clear_out=f_clear_out=1, error:=1, then go to IDLE. configured is cleared if the abort came from CFG_*; it is kept if the abort came from OUT_*.
- Pending write:
  - write_enable_in=1 in any state other than IDLE sets pending. A further write_enable_in while pending is already set is dropped.
  - write_enable_in while configured=0 is ignored and not latched.
- Latency:
  - Start bit to CFG_LOAD: 1 cycle.
  - Final rollover_r_in to configured_out=1: 2 cycles.
  - write_enable_in in IDLE to load_data_out: 1 cycle.
  - Final rollover_f_in to done_out: 1 cycle.
- Simultaneous events: rollover_r_in and timeout expiry in the same cycle: the rollover wins.

Decomposition:
- Package mcu_link_pkg holds:
  - state enum mcu_link_state_t;
  - ADDR_NONE=4'hF;
  - CFG_SLOT_W=4, OUT_SEL_W=3.
- Sub-module mcu_link_timeout: a loadable down-counter with clear, enable and an expired output. It is reusable by other serial controllers.

Test Plan:
- NUM_CFG=5: rst, then ss_in=1, mosi_in=1 for 1 cycle, then 5 rollover_r_in pulses 8 cycles apart. Expect addr_out to show 0,1,2,3,4 for one cycle each, and configured_out=1 2 cycles after the 5th pulse.
- NUM_OUT=2, configured: pulse write_enable_in. Expect load_data_out with out_sel_out=0, a rollover_f_in, then load_data_out with out_sel_out=1, a rollover_f_in, then done_out for 1 cycle.
- TIMEOUT_CYC=64: hold CFG_LOAD with no rollover. Expect ABORT at cycle 64, error_out=1, configured_out=0, state_out=0 next cycle.
- Drop ss_in=0 mid OUT_SHIFT. Expect ABORT, configured_out remains 1, no done_out.
- Pulse write_enable_in during OUT_SHIFT. Expect a second OUT_LOAD 1 cycle after the first OUT_DONE→IDLE.
- RECONFIG_EN=0 vs 1: start bit while configured. With 0, expect no state change; with 1, expect configured_out→0 and CFG_LOAD.

Source files
------------

// File: rtl/mcu_link_pkg.sv
// Shared types and constants for the MCU link controller.
package mcu_link_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CFG_LOAD  = 4'd1,
    ST_CFG_STORE = 4'd2,
    ST_OUT_LOAD  = 4'd3,
    ST_OUT_SHIFT = 4'd4,
    ST_OUT_DONE  = 4'd5,
    ST_ABORT     = 4'd6
  } mcu_link_state_t;

  localparam logic [3:0] ADDR_NONE  = 4'hF;
  localparam int         CFG_SLOT_W = 4;
  localparam int         OUT_SEL_W  = 3;

endpackage

// File: rtl/mcu_link_timeout.sv
// Loadable down-counter watchdog. Load it with N-1 on entry to a guarded
// state and enable it while there; expired rises on the N-th enabled cycle.
module mcu_link_timeout #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  // clear beats load beats count; the counter parks at zero
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/mcu_link_ctrl.sv
// MCU link controller: loads NUM_CFG configuration words into the register
// map, then streams NUM_OUT result words through the PTS register for every
// KF write_enable. rollover_r_in / rollover_f_in / write_enable_in are
// single-cycle pulses sampled on the rising clock edge; there is no
// back-pressure, a pulse not consumed in the current state is either latched
// (write request) or ignored (rollovers).
module mcu_link_ctrl
  import mcu_link_pkg::*;
#(
  parameter int NUM_CFG     = 5,
  parameter int NUM_OUT     = 1,
  parameter int TIMEOUT_CYC = 1024,
  parameter int RECONFIG_EN = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_in,
  input  logic       mosi_in,
  input  logic       rollover_r_in,
  input  logic       rollover_f_in,
  input  logic       write_enable_in,
  output logic [3:0] addr_out,
  output logic       configured_out,
  output logic       load_data_out,
  output logic [2:0] out_sel_out,
  output logic       output_ready_out,
  output logic       done_out,
  output logic       r_clear_out,
  output logic       f_clear_out,
  output logic       error_out,
  output logic [3:0] state_out
);

  localparam logic [CFG_SLOT_W-1:0] LAST_SLOT = CFG_SLOT_W'(NUM_CFG - 1);
  localparam logic [OUT_SEL_W-1:0]  LAST_OUT  = OUT_SEL_W'(NUM_OUT - 1);
  localparam logic [15:0]           TO_LOAD   = 16'(TIMEOUT_CYC - 1);

  mcu_link_state_t       state;
  logic [CFG_SLOT_W-1:0] slot;
  logic [OUT_SEL_W-1:0]  out_idx;
  logic                  configured;
  logic                  error;
  logic                  pending;
  logic                  in_cfg;
  logic                  link_busy;
  logic                  start_ok;
  logic                  to_clear;
  logic                  to_load;
  logic                  to_en;
  logic                  to_expired;

  assign in_cfg    = (state == ST_CFG_LOAD) || (state == ST_CFG_STORE);
  assign link_busy = (state != ST_IDLE) && (state != ST_ABORT);
  assign start_ok  = mosi_in && (!configured || (RECONFIG_EN != 0));

  // The watchdog is re-armed in every state that precedes a guarded state,
  // so each word in CFG_LOAD / OUT_SHIFT starts with a full budget.
  assign to_en    = (state == ST_CFG_LOAD) || (state == ST_OUT_SHIFT);
  assign to_load  = (state == ST_IDLE) || (state == ST_CFG_STORE) || (state == ST_OUT_LOAD);
  assign to_clear = (state == ST_ABORT) || (state == ST_OUT_DONE);

  mcu_link_timeout #(.W(16)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (to_clear),
    .load     (to_load),
    .load_val (TO_LOAD),
    .en       (to_en),
    .expired  (to_expired)
  );

  // Main sequencer: slave-select drop beats rollover, rollover beats timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      slot       <= '0;
      out_idx    <= '0;
      configured <= 1'b0;
      error      <= 1'b0;
      pending    <= 1'b0;
    end else begin
      if (write_enable_in && configured && (state != ST_IDLE)) begin
        pending <= 1'b1;
      end
      if (link_busy && !ss_in) begin
        state <= ST_ABORT;
        if (in_cfg) configured <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ss_in) begin
              if (start_ok) begin
                slot       <= '0;
                configured <= 1'b0;
                state      <= ST_CFG_LOAD;
                // a write that collides with the start bit is kept for later
                if (write_enable_in && configured) pending <= 1'b1;
              end else if (configured && (write_enable_in || pending)) begin
                out_idx <= '0;
                pending <= 1'b0;
                state   <= ST_OUT_LOAD;
              end
            end
          end
          ST_CFG_LOAD: begin
            if (rollover_r_in)   state <= ST_CFG_STORE;
            else if (to_expired) state <= ST_ABORT;
          end
          ST_CFG_STORE: begin
            if (slot == LAST_SLOT) begin
              configured <= 1'b1;
              error      <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              slot  <= slot + 1'b1;
              state <= ST_CFG_LOAD;
            end
          end
          ST_OUT_LOAD: state <= ST_OUT_SHIFT;
          ST_OUT_SHIFT: begin
            if (rollover_f_in) begin
              if (out_idx == LAST_OUT) begin
                state <= ST_OUT_DONE;
              end else begin
                out_idx <= out_idx + 1'b1;
                state   <= ST_OUT_LOAD;
              end
            end else if (to_expired) begin
              state <= ST_ABORT;
            end
          end
          ST_OUT_DONE: state <= ST_IDLE;
          ST_ABORT: begin
            error <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Output decode of the registered state and counters
  always_comb begin
    addr_out         = ADDR_NONE;
    load_data_out    = 1'b0;
    out_sel_out      = '0;
    output_ready_out = 1'b0;
    done_out         = 1'b0;
    r_clear_out      = 1'b0;
    f_clear_out      = 1'b0;
    case (state)
      ST_IDLE: begin
        r_clear_out = 1'b1;
        f_clear_out = 1'b1;
      end
      ST_CFG_STORE: begin
        addr_out    = slot;
        r_clear_out = 1'b1;
      end
      ST_OUT_LOAD: begin
        load_data_out = 1'b1;
        f_clear_out   = 1'b1;
        out_sel_out   = out_idx;
      end
      ST_OUT_SHIFT: begin
        output_ready_out = 1'b1;
        out_sel_out      = out_idx;
      end
      ST_OUT_DONE: begin
        done_out    = 1'b1;
        f_clear_out = 1'b1;
      end
      ST_ABORT: begin
        r_clear_out = 1'b1;
        f_clear_out = 1'b1;
      end
      default: ;
    endcase
  end

  assign configured_out = configured;
  assign error_out      = error;
  assign state_out      = state;

endmodule

// File: tb/tb_mcu_link_ctrl.sv
// Bench for mcu_link_ctrl: two instances share all inputs, one with
// reconfiguration disabled and one with it enabled.
module tb_mcu_link_ctrl;

  localparam int NUM_CFG     = 5;
  localparam int NUM_OUT     = 2;
  localparam int TIMEOUT_CYC = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic ss = 1'b0, mosi = 1'b0, rr = 1'b0, rf = 1'b0, we = 1'b0;

  logic [3:0] addr_o [2];
  logic       cfg_o  [2];
  logic       load_o [2];
  logic [2:0] sel_o  [2];
  logic       rdy_o  [2];
  logic       done_o [2];
  logic       rclr_o [2];
  logic       fclr_o [2];
  logic       err_o  [2];
  logic [3:0] st_o   [2];

  mcu_link_ctrl #(.NUM_CFG(NUM_CFG), .NUM_OUT(NUM_OUT), .TIMEOUT_CYC(TIMEOUT_CYC),
                  .RECONFIG_EN(0)) dut0 (
    .clk(clk), .rst(rst), .ss_in(ss), .mosi_in(mosi), .rollover_r_in(rr),
    .rollover_f_in(rf), .write_enable_in(we), .addr_out(addr_o[0]),
    .configured_out(cfg_o[0]), .load_data_out(load_o[0]), .out_sel_out(sel_o[0]),
    .output_ready_out(rdy_o[0]), .done_out(done_o[0]), .r_clear_out(rclr_o[0]),
    .f_clear_out(fclr_o[0]), .error_out(err_o[0]), .state_out(st_o[0]));

  mcu_link_ctrl #(.NUM_CFG(NUM_CFG), .NUM_OUT(NUM_OUT), .TIMEOUT_CYC(TIMEOUT_CYC),
                  .RECONFIG_EN(1)) dut1 (
    .clk(clk), .rst(rst), .ss_in(ss), .mosi_in(mosi), .rollover_r_in(rr),
    .rollover_f_in(rf), .write_enable_in(we), .addr_out(addr_o[1]),
    .configured_out(cfg_o[1]), .load_data_out(load_o[1]), .out_sel_out(sel_o[1]),
    .output_ready_out(rdy_o[1]), .done_out(done_o[1]), .r_clear_out(rclr_o[1]),
    .f_clear_out(fclr_o[1]), .error_out(err_o[1]), .state_out(st_o[1]));

  // reference model: link-level facts per instance
  bit         reconfig_en [2] = '{1'b0, 1'b1};
  bit         model_cfg   [2] = '{1'b0, 1'b0};
  bit         model_err   [2] = '{1'b0, 1'b0};
  logic [2:0] exp_sel_q [$];
  int         exp_done = 0;
  int         done_cnt = 0;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_chk++;
    assert (obs === req) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h at %0t", tag, obs, req, $time);
      $error("check %s", tag);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // scoreboard: every PTS load on dut0 must match the next expected word index
  always @(negedge clk) begin
    if (!rst) begin
      if (done_o[0]) done_cnt++;
      if (load_o[0]) begin
        if (exp_sel_q.size() == 0) chk("load_unexpected", 32'(load_o[0]), 0);
        else chk("load_sel", 32'(sel_o[0]), 32'(exp_sel_q.pop_front()));
      end
    end
  end

  // driver: full configuration sequence, slot checks on instance d
  task automatic configure(input int d, input int first_gap);
    bit acc [2];
    int g;
    for (int k = 0; k < 2; k++) acc[k] = !model_cfg[k] || reconfig_en[k];
    ss = 1'b1; mosi = 1'b1;
    cyc();
    mosi = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("cfg_enter", 32'(st_o[k]), acc[k] ? 1 : 0);
      chk("cfg_flag_on_start", 32'(cfg_o[k]), acc[k] ? 0 : 32'(model_cfg[k]));
    end
    for (int i = 0; i < NUM_CFG; i++) begin
      g = (i == 0 && first_gap >= 0) ? first_gap : int'($urandom_range(0, 7));
      repeat (g) cyc();
      if (g == TIMEOUT_CYC - 1) chk("cfg_last_cycle", 32'(st_o[d]), 1);
      rr = 1'b1;
      cyc();
      rr = 1'b0;
      chk("cfg_store", 32'(st_o[d]), 2);
      chk("cfg_addr", 32'(addr_o[d]), i);
      chk("cfg_rclr", 32'(rclr_o[d]), 1);
      cyc();
      if (i < NUM_CFG - 1) chk("cfg_addr_none", 32'(addr_o[d]), 32'hF);
    end
    for (int k = 0; k < 2; k++) begin
      if (acc[k]) begin
        model_cfg[k] = 1'b1;
        model_err[k] = 1'b0;
      end
      chk("cfg_idle", 32'(st_o[k]), 0);
      chk("cfg_configured", 32'(cfg_o[k]), 32'(model_cfg[k]));
      chk("cfg_error", 32'(err_o[k]), 32'(model_err[k]));
    end
  endtask

  task automatic start_burst();
    for (int j = 0; j < NUM_OUT; j++) exp_sel_q.push_back(3'(j));
    we = 1'b1;
    cyc();
    we = 1'b0;
  endtask

  // driver: one full result burst starting in OUT_LOAD, ending in IDLE
  task automatic out_burst(input bit inject);
    int g;
    for (int j = 0; j < NUM_OUT; j++) begin
      for (int k = 0; k < 2; k++) begin
        chk("out_load", 32'(st_o[k]), 3);
        chk("out_load_strobe", 32'(load_o[k]), 1);
        chk("out_load_fclr", 32'(fclr_o[k]), 1);
      end
      cyc();
      for (int k = 0; k < 2; k++) begin
        chk("out_shift", 32'(st_o[k]), 4);
        chk("out_ready", 32'(rdy_o[k]), 1);
        chk("out_sel", 32'(sel_o[k]), j);
      end
      if (inject) begin
        we = 1'b1;
        cyc();
        we = 1'b0;
      end
      g = int'($urandom_range(0, 5));
      repeat (g) cyc();
      rf = 1'b1;
      cyc();
      rf = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      chk("out_done", 32'(st_o[k]), 5);
      chk("out_done_pulse", 32'(done_o[k]), 1);
    end
    exp_done++;
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("out_back_idle", 32'(st_o[k]), 0);
      chk("out_done_low", 32'(done_o[k]), 0);
    end
  endtask

  task automatic check_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst_state", 32'(st_o[k]), 0);
      chk("rst_addr", 32'(addr_o[k]), 32'hF);
      chk("rst_rclr", 32'(rclr_o[k]), 1);
      chk("rst_fclr", 32'(fclr_o[k]), 1);
      chk("rst_cfg", 32'(cfg_o[k]), 0);
      chk("rst_err", 32'(err_o[k]), 0);
      chk("rst_load", 32'(load_o[k]), 0);
      chk("rst_sel", 32'(sel_o[k]), 0);
      chk("rst_ready", 32'(rdy_o[k]), 0);
      chk("rst_done", 32'(done_o[k]), 0);
    end
  endtask

  // time bound on the whole run
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    repeat (3) cyc();
    check_reset();
    rst = 1'b0;
    cyc();

    // write request while unconfigured is ignored and not latched
    ss = 1'b1; we = 1'b1;
    cyc();
    we = 1'b0;
    for (int k = 0; k < 2; k++) chk("we_unconfigured", 32'(st_o[k]), 0);
    cyc();
    for (int k = 0; k < 2; k++) chk("we_not_latched", 32'(st_o[k]), 0);

    // configuration watchdog: no rollover for TIMEOUT_CYC cycles
    mosi = 1'b1;
    cyc();
    mosi = 1'b0;
    repeat (TIMEOUT_CYC - 1) cyc();
    for (int k = 0; k < 2; k++) chk("to_still_loading", 32'(st_o[k]), 1);
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("to_abort", 32'(st_o[k]), 6);
      chk("to_abort_clears", 32'({rclr_o[k], fclr_o[k]}), 3);
    end
    cyc();
    for (int k = 0; k < 2; k++) begin
      model_err[k] = 1'b1;
      chk("to_idle", 32'(st_o[k]), 0);
      chk("to_error", 32'(err_o[k]), 32'(model_err[k]));
      chk("to_unconfigured", 32'(cfg_o[k]), 32'(model_cfg[k]));
    end

    // configure both instances, then a few plain bursts
    configure(0, -1);
    repeat (int'($urandom_range(1, 4))) cyc();
    for (int n = 0; n < 3; n++) begin
      start_burst();
      out_burst(1'b0);
      repeat (int'($urandom_range(0, 3))) cyc();
    end

    // write requests during shifting: one is kept, the second is dropped
    start_burst();
    out_burst(1'b1);
    for (int j = 0; j < NUM_OUT; j++) exp_sel_q.push_back(3'(j));
    cyc();
    out_burst(1'b0);
    repeat (2) cyc();
    for (int k = 0; k < 2; k++) chk("no_third_burst", 32'(st_o[k]), 0);

    // slave-select drop mid-shift aborts and keeps the configuration
    exp_sel_q.push_back(3'd0);
    we = 1'b1;
    cyc();
    we = 1'b0;
    cyc();
    for (int k = 0; k < 2; k++) chk("ss_drop_shift", 32'(st_o[k]), 4);
    ss = 1'b0;
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("ss_drop_abort", 32'(st_o[k]), 6);
      chk("ss_drop_no_done", 32'(done_o[k]), 0);
    end
    ss = 1'b1;
    cyc();
    for (int k = 0; k < 2; k++) begin
      model_err[k] = 1'b1;
      chk("ss_drop_idle", 32'(st_o[k]), 0);
      chk("ss_drop_cfg_kept", 32'(cfg_o[k]), 32'(model_cfg[k]));
      chk("ss_drop_error", 32'(err_o[k]), 32'(model_err[k]));
    end

    // start bit while configured: only the reconfigurable instance restarts
    configure(1, -1);
    cyc();
    start_burst();
    out_burst(1'b0);

    // second reset, then rollover in the last allowed cycle of a word
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      model_cfg[k] = 1'b0;
      model_err[k] = 1'b0;
    end
    repeat (2) cyc();
    check_reset();
    rst = 1'b0;
    cyc();
    configure(0, TIMEOUT_CYC - 1);
    start_burst();
    out_burst(1'b0);

    // end-of-run scoreboard state
    repeat (3) cyc();
    chk("done_count", 32'(done_cnt), 32'(exp_done));
    chk("sel_queue_drained", 32'(exp_sel_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
